fsm_serial_pattern_tx: RTL and testbench
========================================

Name: fsm_serial_pattern_tx

Overview:
- Transmit side of the single-bit `din` serial stream consumed by the team's Mealy sequence-detector FSMs.
- Accepts a parallel word over a valid/ready handshake and serialises it MSB-first on `dout`, with a `dout_valid` qualifier.
- Inserts a programmable idle gap between frames.
- Built as a 3-process FSM (state register, next-state decoder, Mealy output decoder) plus datapath registers.

Parameters:
- DATA_W, 8, payload bits per frame (legal range 2..32).
- GAP_CYC, 2, idle cycles inserted after each frame (legal range 0..15).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_W  word to serialise; must be held stable until accepted.
- in_ready  output  1  Mealy output, =1 only in IDLE.
- dout  output  1  serial data bit.
- dout_valid  output  1  =1 while a frame bit is on `dout`.
- done  output  1  Mealy pulse, =1 during the last frame bit.
- busy  output  1  =1 in any state other than IDLE.
- p_state  output  2  debug: present state.

Behaviour:
- Reset (async, rst=1):
  - p_state=IDLE; shift register, bit counter and gap counter cleared.
  - dout=0, dout_valid=0, done=0, busy=0, in_ready=1 once rst deasserts.
  - Reset mid-frame aborts the frame immediately; the aborted word is never resumed.
- States (2-bit): IDLE=2'b00, SHIFT=2'b01, GAP=2'b10; 2'b11 is illegal and decodes to next state IDLE with all outputs 0.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at the clock edge: load shreg<=in_data, bitcnt<=DATA_W-1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - dout=shreg[DATA_W-1], dout_valid=1, busy=1, in_ready=0.
  - Each edge: shreg<=shreg<<1 and bitcnt<=bitcnt-1.
  - done=1 when bitcnt==0 (combinational Mealy decode of state and count).
  - On the edge with bitcnt==0: go to GAP if GAP_CYC>0 (gapcnt<=GAP_CYC-1), else go to IDLE.
- GAP:
  - dout=0, dout_valid=0, busy=1, in_ready=0.
  - Each edge decrements gapcnt; on gapcnt==0 go to IDLE.
- Timing:
  - Word accepted at edge E → first bit visible in cycle E+1, last bit in cycle E+DATA_W.
  - in_ready returns in cycle E+DATA_W+GAP_CYC+1.
- Minimum frame spacing is one IDLE cycle, so GAP_CYC=0 gives back-to-back frames separated by one dead cycle.
- Outside SHIFT: dout=0 and done=0.
- in_valid while busy is ignored and causes no double accept.
- in_data changing while in_ready=0 has no effect.
- Counter widths: bitcnt is $clog2(DATA_W) bits; gapcnt is 4 bits. No wrap occurs within legal parameter ranges.

Optional Feature:
- Macro: FSM_TX_PARITY_EN.
- Defined:
  - After the last data bit, one extra SHIFT cycle drives the even-parity bit (^in_data, captured at load) with dout_valid=1.
  - done moves to the parity cycle; frame length becomes DATA_W+1.
  - All gap and in_ready timing shifts by +1.
- Undefined: no parity logic and frame length DATA_W; behaviour exactly as above.

Decomposition:
- Package fsm_tx_pkg holds:
  - the state encodings IDLE/SHIFT/GAP and the state-vector width (2);
  - shared with the receiver-side FSMs so that debug p_state values match.
- Sub-module fsm_tx_shiftreg (parameter DATA_W):
  - inputs: load, shift, d; outputs: msb, parity;
  - instantiated once.
- The FSM and both counters stay in the top module.

Test Plan:
- DATA_W=8, GAP_CYC=2, in_data=8'hA5 accepted at edge 0:
  - dout=1,0,1,0,0,1,0,1 in cycles 1–8 with dout_valid=1; done=1 only in cycle 8;
  - dout_valid=0 in cycles 9–10; in_ready=1 in cycle 11.
- in_valid held high with 8'h3C then 8'hC3:
  - exactly one accept per IDLE visit; streams 00111100 then 11000011;
  - no word skipped or duplicated.
- GAP_CYC=0, two back-to-back words: exactly one dead cycle (dout_valid=0, in_ready=1) between frames.
- rst pulsed asynchronously after 3 bits of 8'hFF: outputs go to 0 immediately with no clock edge needed; p_state=00; the next accepted word 8'h81 serialises cleanly as 10000001.
- FSM_TX_PARITY_EN defined:
  - 8'hA5 → 9th bit 0 with done in cycle 9;
  - 8'h07 → 9th bit 1.
- Force p_state=2'b11 via the bench: next cycle p_state=00, dout=0 and dout_valid=0 throughout.

Source files
------------

// File: rtl/fsm_tx_pkg.sv
// Shared state encoding for the serial pattern transmitter and the receiver-side FSMs,
// so debug p_state values line up across blocks.
package fsm_tx_pkg;

   localparam int STATE_W  = 2;
   localparam int GAPCNT_W = 4;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      GAP   = 2'b10
   } state_t;

endpackage

// File: rtl/fsm_tx_shiftreg.sv
// MSB-first parallel-to-serial shift register with even parity captured at load.
// Parity is only built when FSM_TX_PARITY_EN is defined; otherwise it reads 0.
module fsm_tx_shiftreg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] d,
   output logic              msb,
   output logic              parity
);

   logic [DATA_W-1:0] shreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
      end else if (load) begin
         shreg <= d;
      end else if (shift) begin
         shreg <= {shreg[DATA_W-2:0], 1'b0};
      end
   end

   assign msb = shreg[DATA_W-1];

`ifdef FSM_TX_PARITY_EN
   logic par;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par <= 1'b0;
      end else if (load) begin
         par <= ^d;
      end
   end

   assign parity = par;
`else
   assign parity = 1'b0;
`endif

endmodule

// File: rtl/fsm_serial_pattern_tx.sv
// Serialises a handshaked parallel word MSB-first on dout, then idles GAP_CYC cycles.
// Define FSM_TX_PARITY_EN to append an even-parity bit to every frame.
module fsm_serial_pattern_tx
   import fsm_tx_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int GAP_CYC = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               dout,
   output logic               dout_valid,
   output logic               done,
   output logic               busy,
   output logic [STATE_W-1:0] p_state
);

   localparam int CNT_W = $clog2(DATA_W);

   state_t              state;
   state_t              state_nx;
   logic [CNT_W-1:0]    bitcnt;
   logic [GAPCNT_W-1:0] gapcnt;
   logic                load;
   logic                last_bit;
   logic                msb;
   logic                ser_bit;

   assign load = (state == IDLE) && in_valid;

`ifdef FSM_TX_PARITY_EN
   logic parity;
   logic par_phase;

   // The parity cycle is an extra SHIFT cycle flagged by par_phase, so bitcnt keeps its width.
   assign last_bit = (bitcnt == '0) && par_phase;
   assign ser_bit  = par_phase ? parity : msb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_phase <= 1'b0;
      end else if (load) begin
         par_phase <= 1'b0;
      end else if ((state == SHIFT) && (bitcnt == '0)) begin
         par_phase <= 1'b1;
      end
   end
`else
   logic parity_unused;

   assign last_bit = (bitcnt == '0);
   assign ser_bit  = msb;
`endif

   fsm_tx_shiftreg #(
      .DATA_W (DATA_W)
   ) u_shiftreg (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .shift  (state == SHIFT),
      .d      (in_data),
      .msb    (msb),
`ifdef FSM_TX_PARITY_EN
      .parity (parity)
`else
      .parity (parity_unused)
`endif
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = SHIFT;
         SHIFT:   if (last_bit) state_nx = (GAP_CYC > 0) ? GAP : IDLE;
         GAP:     if (gapcnt == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Mealy output decode; the unused 2'b11 code falls to the all-zero default.
   always_comb begin
      in_ready   = 1'b0;
      dout       = 1'b0;
      dout_valid = 1'b0;
      done       = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         SHIFT: begin
            dout       = ser_bit;
            dout_valid = 1'b1;
            done       = last_bit;
            busy       = 1'b1;
         end
         GAP:     busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitcnt <= '0;
         gapcnt <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) bitcnt <= CNT_W'(DATA_W - 1);
            SHIFT: begin
               if (bitcnt != '0) bitcnt <= bitcnt - CNT_W'(1);
               if (last_bit) gapcnt <= GAPCNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
            end
            GAP:     if (gapcnt != '0) gapcnt <= gapcnt - GAPCNT_W'(1);
            default: ;
         endcase
      end
   end

   assign p_state = state;

endmodule

// File: tb/tb_fsm_serial_pattern_tx.sv
// Scoreboard bench: two transmitters (GAP_CYC=2 and GAP_CYC=0) share one randomized stimulus
// stream; a frame-level model predicts bits and ready timing, a negedge monitor compares.
module tb_fsm_serial_pattern_tx;
   import fsm_tx_pkg::*;

   localparam int DATA_W = 8;
`ifdef FSM_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL = DATA_W + PAR;
   localparam int GAP0 = 2;
   localparam int GAP1 = 0;

   logic clk = 1'b0;
   logic rst;
   logic in_valid;
   logic [DATA_W-1:0] in_data;

   logic rdy0, dout0, dv0, done0, busy0;
   logic rdy1, dout1, dv1, done1, busy1;
   logic [1:0] ps0, ps1;

   int checks = 0;
   int errors = 0;
   bit forcing = 1'b0;

   int busy_left [2];
   bit [1:0] expq [2][$];

   always #5 clk = ~clk;

   fsm_serial_pattern_tx #(.DATA_W(DATA_W), .GAP_CYC(GAP0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy0), .dout(dout0), .dout_valid(dv0), .done(done0),
      .busy(busy0), .p_state(ps0));

   fsm_serial_pattern_tx #(.DATA_W(DATA_W), .GAP_CYC(GAP1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .dout(dout1), .dout_valid(dv1), .done(done1),
      .busy(busy1), .p_state(ps1));

   task automatic chk(input string name, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", name, inst, $time, act, exp);
      end
   endtask

   // Frame-level reference: an accepted word becomes FL expected bits and the
   // transmitter is unavailable for FL + gap cycles.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            busy_left[i] = 0;
            expq[i].delete();
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (busy_left[i] == 0) begin
               if (in_valid) begin
                  logic [DATA_W-1:0] w;
                  w = in_data;
                  for (int b = DATA_W - 1; b >= 0; b--)
                     expq[i].push_back({w[b], (PAR == 0) && (b == 0)});
                  if (PAR != 0) expq[i].push_back({^w, 1'b1});
                  busy_left[i] = FL + ((i == 0) ? GAP0 : GAP1);
               end
            end else begin
               busy_left[i]--;
            end
         end
      end
   end

   task automatic monitor_inst(input int i, input logic r, input logic b, input logic v,
                               input logic d, input logic dn);
      bit [1:0] e;
      chk("in_ready", i, r, busy_left[i] == 0);
      chk("busy", i, b, busy_left[i] != 0);
      chk("dout_valid", i, v, expq[i].size() != 0);
      if (expq[i].size() != 0) begin
         e = expq[i].pop_front();
         chk("dout", i, d, e[1]);
         chk("done", i, dn, e[0]);
      end else begin
         chk("dout_idle", i, d, 0);
         chk("done_idle", i, dn, 0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (!forcing) monitor_inst(0, rdy0, busy0, dv0, dout0, done0);
         monitor_inst(1, rdy1, busy1, dv1, dout1, done1);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs();
      chk("rst_p_state", 0, ps0, 0);
      chk("rst_dout", 0, dout0, 0);
      chk("rst_dout_valid", 0, dv0, 0);
      chk("rst_done", 0, done0, 0);
      chk("rst_busy", 0, busy0, 0);
      chk("rst_p_state", 1, ps1, 0);
      chk("rst_dout", 1, dout1, 0);
      chk("rst_dout_valid", 1, dv1, 0);
      chk("rst_done", 1, done1, 0);
      chk("rst_busy", 1, busy1, 0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      #2;
      check_reset_outputs();
      step(2);
      rst = 1'b0;
      step(1);

      // Single 8'hA5 frame.
      in_valid = 1'b1;
      in_data = 8'hA5;
      step(1);
      in_valid = 1'b0;
      step(14);

      // Valid held high across two words.
      in_valid = 1'b1;
      in_data = 8'h3C;
      step(5);
      in_data = 8'hC3;
      step(20);
      in_valid = 1'b0;
      step(15);

      // Parity-distinguishing word.
      in_valid = 1'b1;
      in_data = 8'h07;
      step(1);
      in_valid = 1'b0;
      step(14);

      repeat (300) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data = DATA_W'($urandom);
         step(1);
      end
      in_valid = 1'b0;
      step(15);

      // Asynchronous reset during the third bit of 8'hFF.
      in_valid = 1'b1;
      in_data = 8'hFF;
      step(1);
      in_valid = 1'b0;
      step(2);
      #1 rst = 1'b1;
      #1 check_reset_outputs();
      step(1);
      rst = 1'b0;
      step(1);
      in_valid = 1'b1;
      in_data = 8'h81;
      step(1);
      in_valid = 1'b0;
      step(12);

      // Illegal state code recovers to IDLE with outputs held low.
      forcing = 1'b1;
      force dut0.state = state_t'(2'b11);
      #1;
      chk("ill_p_state", 0, ps0, 2'b11);
      chk("ill_dout", 0, dout0, 0);
      chk("ill_dout_valid", 0, dv0, 0);
      chk("ill_in_ready", 0, rdy0, 0);
      chk("ill_busy", 0, busy0, 0);
      chk("ill_done", 0, done0, 0);
      release dut0.state;
      step(1);
      chk("ill_recover_p_state", 0, ps0, 0);
      chk("ill_recover_dout_valid", 0, dv0, 0);
      forcing = 1'b0;
      step(5);

      for (int i = 0; i < 2; i++) chk("queue_drained", i, expq[i].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
